breath_pwm_fader: RTL and testbench

- Downstream stage of the 4-LED breathing sequencer. Consumes its four active-low LED enable levels and drives the board LED pins.
- Replaces hard on/off switching with a PWM brightness envelope. Each enabled channel continuously ramps brightness up and then down (triangle "breath").
- A channel that is disabled fades out to dark instead of cutting off.
- All channels share one PWM period counter. Each channel owns a duty register and a 3-state FSM.

---
 rtl/breath_pkg.sv | 16 +
 rtl/breath_pwm_chan.sv | 105 ++++++++++
 rtl/breath_pwm_fader.sv | 57 +++++
 tb/tb_breath_pwm_fader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// Shared definitions for the breathing PWM fader.
// Holds the per-channel state encoding and the default PWM period / duty step
// used when the fader is instantiated without overrides.
package breath_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } breath_state_e;

  // 1000 clocks at 50 MHz gives a 50 kHz PWM carrier.
  localparam int DEF_PWM_PERIOD = 1000;
  localparam int DEF_DUTY_STEP  = 2;

endpackage

// File: rtl/breath_pwm_chan.sv
// One breathing LED channel: state machine, duty register and PWM compare.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   cnt_pwm    shared PWM period counter, 0..PWM_PERIOD-1
//   period_end high on the last count of each PWM period
//   en         channel enable (active-high, already inverted by the top)
//   led_n      registered PWM drive, 0 = lit
//   duty       current duty register
module breath_pwm_chan
  import breath_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int DUTY_STEP  = DEF_DUTY_STEP,
  parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cnt_pwm,
  input  logic          period_end,
  input  logic          en,
  output logic          led_n,
  output logic [DW-1:0] duty
);

  localparam logic [DW-1:0] STEP_D = DW'(DUTY_STEP);
  localparam logic [DW-1:0] PER_D  = DW'(PWM_PERIOD);
  localparam logic [DW:0]   STEP_X = (DW + 1)'(DUTY_STEP);
  localparam logic [DW:0]   PER_X  = (DW + 1)'(PWM_PERIOD);

  breath_state_e r_state;
  breath_state_e w_state_nxt;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] w_duty_nxt;
  logic          r_led_n;

  // Sums carry one extra bit so the top-of-ramp test cannot wrap.
  logic [DW:0]   w_up;
  logic [DW-1:0] w_dn;
  logic          w_le_step;

  assign w_up      = {1'b0, r_duty} + STEP_X;
  assign w_dn      = r_duty - STEP_D;   // only used when r_duty > DUTY_STEP
  assign w_le_step = ({1'b0, r_duty} <= STEP_X);

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    if (period_end) begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_state_nxt = ST_RISE;
            w_duty_nxt  = STEP_D;
          end else begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
          end
        end
        ST_RISE: begin
          if (!en) begin
            // Disable mid-ramp turns straight into a fade-out.
            w_state_nxt = ST_FALL;
            w_duty_nxt  = w_le_step ? '0 : w_dn;
          end else if (w_up >= PER_X) begin
            w_state_nxt = ST_FALL;
            w_duty_nxt  = PER_D;
          end else begin
            w_duty_nxt  = w_up[DW-1:0];
          end
        end
        ST_FALL: begin
          if (w_le_step) begin
            // Bottom of the breath: restart or go dark with no idle period.
            w_duty_nxt  = '0;
            w_state_nxt = en ? ST_RISE : ST_IDLE;
          end else begin
            w_duty_nxt  = w_dn;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_led_n <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      // Compare uses the duty committed at the previous period end.
      r_led_n <= (cnt_pwm < r_duty) ? 1'b0 : 1'b1;
    end
  end

  assign led_n = r_led_n;
  assign duty  = r_duty;

endmodule

// File: rtl/breath_pwm_fader.sv
// Four-channel breathing PWM fader placed after the LED sequencer.
// Each enabled channel ramps its brightness up and down as a triangle; a
// disabled channel fades to dark. One PWM period counter is shared.
// Ports:
//   clk        system clock (50 MHz)
//   rst_n      synchronous active-low reset
//   led_in_n   per-channel enable, 0 = on
//   led_out_n  PWM drive to the LED pins, 0 = lit
//   duty_dbg   concatenated duty registers, channel 3 in the MSBs
module breath_pwm_fader
  import breath_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int DUTY_STEP  = DEF_DUTY_STEP,
  parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      led_in_n,
  output logic [3:0]      led_out_n,
  output logic [4*DW-1:0] duty_dbg
);

  localparam logic [DW-1:0] CNT_MAX = DW'(PWM_PERIOD - 1);

  logic [DW-1:0] r_cnt_pwm;
  logic          w_period_end;

  assign w_period_end = (r_cnt_pwm == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_pwm <= '0;
    end else if (w_period_end) begin
      r_cnt_pwm <= '0;
    end else begin
      r_cnt_pwm <= r_cnt_pwm + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    breath_pwm_chan #(
      .PWM_PERIOD (PWM_PERIOD),
      .DUTY_STEP  (DUTY_STEP),
      .DW         (DW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_pwm    (r_cnt_pwm),
      .period_end (w_period_end),
      .en         (~led_in_n[gi]),
      .led_n      (led_out_n[gi]),
      .duty       (duty_dbg[gi*DW +: DW])
    );
  end

endmodule

// File: tb/tb_breath_pwm_fader.sv
// Self-checking bench for breath_pwm_fader with PWM_PERIOD=10, DUTY_STEP=2.
module tb_breath_pwm_fader;

  localparam int P  = 10;
  localparam int S  = 2;
  localparam int DW = $clog2(P + 1);

  logic            clk;
  logic            rst_n;
  logic [3:0]      led_in_n;
  logic [3:0]      led_out_n;
  logic [4*DW-1:0] duty_dbg;

  int n_tests;
  int n_fail;

  // Reference model: plain integers, direction -1/0/+1 for fall/idle/rise.
  int       m_cnt;
  int       m_duty [4];
  int       m_dir  [4];
  logic [3:0] m_led;
  bit       m_pe;

  breath_pwm_fader #(
    .PWM_PERIOD (P),
    .DUTY_STEP  (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_in_n  (led_in_n),
    .led_out_n (led_out_n),
    .duty_dbg  (duty_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rstn_v, input logic [3:0] in_n);
    bit en;
    m_pe = 0;
    if (!rstn_v) begin
      m_cnt = 0;
      m_led = 4'hF;
      for (int i = 0; i < 4; i++) begin
        m_duty[i] = 0;
        m_dir[i]  = 0;
      end
      return;
    end
    for (int i = 0; i < 4; i++) m_led[i] = (m_cnt < m_duty[i]) ? 1'b0 : 1'b1;
    if (m_cnt == P - 1) begin
      m_pe = 1;
      for (int i = 0; i < 4; i++) begin
        en = !in_n[i];
        if (m_dir[i] == 0) begin
          if (en) begin m_dir[i] = 1; m_duty[i] = S; end
          else m_duty[i] = 0;
        end else if (m_dir[i] == 1) begin
          if (!en) begin
            m_dir[i]  = -1;
            m_duty[i] = (m_duty[i] - S < 0) ? 0 : m_duty[i] - S;
          end else if (m_duty[i] + S >= P) begin
            m_duty[i] = P;
            m_dir[i]  = -1;
          end else m_duty[i] = m_duty[i] + S;
        end else begin
          if (m_duty[i] <= S) begin
            m_duty[i] = 0;
            m_dir[i]  = en ? 1 : 0;
          end else m_duty[i] = m_duty[i] - S;
        end
      end
    end
    m_cnt = (m_cnt + 1) % P;
  endtask

  function automatic logic [4*DW-1:0] exp_duty();
    logic [4*DW-1:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[i*DW +: DW] = DW'(m_duty[i]);
    return e;
  endfunction

  // Apply inputs, take one clock edge, then compare DUT against the model.
  task automatic cycle(input logic rstn_v, input logic [3:0] in_n);
    rst_n    = rstn_v;
    led_in_n = in_n;
    @(posedge clk);
    model_step(rstn_v, in_n);
    #1;
    check("led_out_n", 32'(led_out_n), 32'(m_led));
    check("duty_dbg", 32'(duty_dbg), 32'(exp_duty()));
  endtask

  int s2_tab [11] = '{2, 4, 6, 8, 10, 8, 6, 4, 2, 0, 2};

  initial begin
    int k;
    int hold;
    logic [3:0] v;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    led_in_n = 4'hF;
    m_cnt    = 0;
    m_led    = 4'hF;
    m_pe     = 0;
    for (int i = 0; i < 4; i++) begin m_duty[i] = 0; m_dir[i] = 0; end

    // Scenario 1: reset and all channels off.
    cycle(1'b0, 4'hF);
    check("reset_led", 32'(led_out_n), 32'hF);
    check("reset_duty", 32'(duty_dbg), 32'h0);
    for (int c = 0; c < 100; c++) cycle(1'b1, 4'hF);
    check("s1_duty", 32'(duty_dbg), 32'h0);

    // Scenario 2: channel 0 breathing, duty table after each period end.
    cycle(1'b0, 4'hF);
    k = 0;
    for (int c = 0; c < 200 && k < 11; c++) begin
      cycle(1'b1, 4'b1110);
      if (m_pe) begin
        check("s2_duty_ch0", 32'(duty_dbg[DW-1:0]), 32'(s2_tab[k]));
        k++;
      end
    end
    check("s2_done", 32'(k), 32'd11);

    // Scenario 3: channel 1 disabled at duty 6 while rising.
    cycle(1'b0, 4'hF);
    k = 0;
    while (k < 200 && !(m_duty[1] == 6 && m_dir[1] == 1)) begin
      cycle(1'b1, 4'b1101);
      k++;
    end
    check("s3_reach6", 32'(duty_dbg[DW +: DW]), 32'd6);
    for (int c = 0; c < 5 * P; c++) cycle(1'b1, 4'hF);
    check("s3_duty_ch1", 32'(duty_dbg[DW +: DW]), 32'd0);
    check("s3_led_ch1", 32'(led_out_n[1]), 32'd1);

    // Scenario 4: all enabled together, channel 2 dropped 3 periods later.
    cycle(1'b0, 4'hF);
    for (int c = 0; c < 3 * P; c++) cycle(1'b1, 4'b0000);
    for (int c = 0; c < 12 * P; c++) cycle(1'b1, 4'b0100);
    check("s4_ch2_dark", 32'(duty_dbg[2*DW +: DW]), 32'd0);

    // Scenario 5: reset pulse while channel 3 sits at duty 8.
    cycle(1'b0, 4'hF);
    k = 0;
    while (k < 200 && m_duty[3] != 8) begin
      cycle(1'b1, 4'b0111);
      k++;
    end
    check("s5_reach8", 32'(duty_dbg[3*DW +: DW]), 32'd8);
    cycle(1'b0, 4'b0111);
    check("s5_rst_led", 32'(led_out_n), 32'hF);
    check("s5_rst_duty", 32'(duty_dbg), 32'h0);
    for (int c = 0; c < P; c++) cycle(1'b1, 4'b0111);
    check("s5_restart", 32'(duty_dbg[3*DW +: DW]), 32'd2);

    // Scenario 6: short enable pulse entirely between period ends.
    cycle(1'b0, 4'hF);
    cycle(1'b1, 4'hF);
    cycle(1'b1, 4'hF);
    for (int c = 0; c < 3; c++) cycle(1'b1, 4'b1110);
    for (int c = 0; c < 3 * P; c++) cycle(1'b1, 4'hF);
    check("s6_ignored", 32'(duty_dbg[DW-1:0]), 32'd0);

    // Randomized segments with occasional reset pulses.
    for (int seg = 0; seg < 150; seg++) begin
      v    = 4'($urandom);
      hold = $urandom_range(1, 40);
      if ($urandom_range(0, 24) == 0) cycle(1'b0, v);
      for (int c = 0; c < hold; c++) cycle(1'b1, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
